// File: rtl/hs_fifo_pipeline.sv
// hs_fifo_pipeline
//   DEPTH-entry FIFO with a req/ack handshake on both sides. It decouples a
//   handshake producer from a handshake consumer that may sit in another
//   timing domain. Both sides speak either four-phase (return-to-zero) or
//   two-phase (transition) signalling. req_in and ack_in can optionally pass
//   through synchroniser flops first.
//
// Parameters
//   DATA_WIDTH   payload width
//   DEPTH        number of entries (power of two, 2..256)
//   PHASE_MODE   0 = four-phase, 1 = two-phase
//   SYNC_STAGES  synchroniser flops on req_in/ack_in (0 = none, else 2..3)
//
// Ports
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   req_in    upstream request; data_in is valid while it is pending
//   ack_out   acknowledge back to upstream
//   data_in   upstream payload
//   req_out   request to downstream
//   ack_in    downstream acknowledge
//   data_out  downstream payload; stable while a request is pending
//   count     number of entries held (an offered entry counts until popped)
//   full      count == DEPTH
//   empty     count == 0
module hs_fifo_pipeline #(
  parameter int DATA_WIDTH  = 3,
  parameter int DEPTH       = 4,
  parameter int PHASE_MODE  = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_in,
  output logic                         ack_out,
  input  logic [DATA_WIDTH-1:0]        data_in,
  output logic                         req_out,
  input  logic                         ack_in,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic                  rq;
  logic                  ak;
  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      rptr;
  logic                  pending;
  logic                  push;
  logic                  pop;
  logic                  offer;
  logic [CNT_W-1:0]      count_next;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---- input synchroniser stage ----
  if (SYNC_STAGES == 0) begin : g_nosync
    assign rq = req_in;
    assign ak = ack_in;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] req_sync;
    logic [SYNC_STAGES-1:0] ack_sync;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        req_sync <= '0;
        ack_sync <= '0;
      end else begin
        req_sync[0] <= req_in;
        ack_sync[0] <= ack_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          req_sync[i] <= req_sync[i-1];
          ack_sync[i] <= ack_sync[i-1];
        end
      end
    end

    assign rq = req_sync[SYNC_STAGES-1];
    assign ak = ack_sync[SYNC_STAGES-1];
  end

  // Handshake decisions. An entry stays counted while it is offered, so an
  // offer never competes with a pop: offer needs !pending, pop needs pending.
  always_comb begin
    push = 1'b0;
    pop  = 1'b0;
    offer = 1'b0;
    if (PHASE_MODE == 0) begin
      push  = rq & ~ack_out & ~full;
      offer = ~empty & ~req_out & ~ak & ~pending;
      pop   = pending & ak;
    end else begin
      push  = (rq != ack_out) & ~full;
      offer = ~empty & ~pending;
      pop   = pending & (ak == req_out);
    end
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // ---- storage: written only on the push edge, never reset ----
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= data_in;
    end
  end

  // ---- write side / read side control stage ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_out  <= 1'b0;
      req_out  <= 1'b0;
      data_out <= '0;
      wptr     <= '0;
      rptr     <= '0;
      pending  <= 1'b0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
    end else begin
      if (PHASE_MODE == 0) begin
        if (push) begin
          ack_out <= 1'b1;
        end else if (!rq && ack_out) begin
          ack_out <= 1'b0;
        end
      end else if (push) begin
        ack_out <= rq;
      end

      if (push) begin
        wptr <= wptr + PTR_W'(1);
      end

      if (offer) begin
        data_out <= mem[rptr];
        req_out  <= (PHASE_MODE == 0) ? 1'b1 : ~req_out;
        pending  <= 1'b1;
      end

      if (pop) begin
        rptr    <= rptr + PTR_W'(1);
        pending <= 1'b0;
        if (PHASE_MODE == 0) begin
          req_out <= 1'b0;
        end
      end

      count <= count_next;
      full  <= (count_next == DEPTH_CNT);
      empty <= (count_next == '0);
    end
  end

endmodule

// File: tb/tb_hs_fifo_pipeline.sv
// Bench for hs_fifo_pipeline. Three instances share clk/rst_n:
//   A: four-phase, no synchronisers   (cycle table, full, reset, random)
//   B: two-phase, no synchronisers
//   C: four-phase, two synchroniser flops
module tb_hs_fifo_pipeline;
  localparam int DW    = 3;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic a_req_in, a_ack_out, a_req_out, a_ack_in, a_full, a_empty;
  logic [DW-1:0] a_data_in, a_data_out;
  logic [CW-1:0] a_count;
  logic b_req_in, b_ack_out, b_req_out, b_ack_in, b_full, b_empty;
  logic [DW-1:0] b_data_in, b_data_out;
  logic [CW-1:0] b_count;
  logic c_req_in, c_ack_out, c_req_out, c_ack_in, c_full, c_empty;
  logic [DW-1:0] c_data_in, c_data_out;
  logic [CW-1:0] c_count;

  hs_fifo_pipeline #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PHASE_MODE(0), .SYNC_STAGES(0)) u_a (
    .clk(clk), .rst_n(rst_n), .req_in(a_req_in), .ack_out(a_ack_out), .data_in(a_data_in),
    .req_out(a_req_out), .ack_in(a_ack_in), .data_out(a_data_out), .count(a_count),
    .full(a_full), .empty(a_empty));
  hs_fifo_pipeline #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PHASE_MODE(1), .SYNC_STAGES(0)) u_b (
    .clk(clk), .rst_n(rst_n), .req_in(b_req_in), .ack_out(b_ack_out), .data_in(b_data_in),
    .req_out(b_req_out), .ack_in(b_ack_in), .data_out(b_data_out), .count(b_count),
    .full(b_full), .empty(b_empty));
  hs_fifo_pipeline #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PHASE_MODE(0), .SYNC_STAGES(2)) u_c (
    .clk(clk), .rst_n(rst_n), .req_in(c_req_in), .ack_out(c_ack_out), .data_in(c_data_in),
    .req_out(c_req_out), .ack_in(c_ack_in), .data_out(c_data_out), .count(c_count),
    .full(c_full), .empty(c_empty));

  int vectors = 0;
  int miscompares = 0;

  // Reference FIFO contents for the randomized run: values acknowledged
  // upstream and not yet delivered downstream.
  logic [DW-1:0] model_q[$];

  typedef struct {
    int req; int din; int ack;
    int e_ack_out; int e_req_out; int e_dout; int e_count; int e_full; int e_empty;
  } vec_t;
  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timeout waiting for handshake", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_req_in = 0; a_ack_in = 0; a_data_in = '0;
    b_req_in = 0; b_ack_in = 0; b_data_in = '0;
    c_req_in = 0; c_ack_in = 0; c_data_in = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Four-phase push into A; optionally records the value in the model once acked.
  task automatic a_push(input logic [DW-1:0] v, input bit rec, input string name);
    int n;
    a_data_in = v;
    a_req_in  = 1'b1;
    n = 0;
    while (a_ack_out !== 1'b1 && n < 200) begin step(); n++; end
    if (a_ack_out !== 1'b1) timeout_fail({name, "_ack_rise"});
    if (rec) model_q.push_back(v);
    a_req_in = 1'b0;
    n = 0;
    while (a_ack_out !== 1'b0 && n < 200) begin step(); n++; end
    if (a_ack_out !== 1'b0) timeout_fail({name, "_ack_fall"});
  endtask

  // Four-phase pop from A; compares data_out while the request is pending.
  task automatic a_pop(input logic [DW-1:0] exp, input bit use_model, input int dly,
                       input string name);
    int n;
    logic [DW-1:0] want;
    n = 0;
    while (a_req_out !== 1'b1 && n < 200) begin step(); n++; end
    if (a_req_out !== 1'b1) begin
      timeout_fail({name, "_req_rise"});
    end else begin
      want = exp;
      if (use_model) begin
        if (model_q.size() == 0) begin
          timeout_fail({name, "_model_empty"});
          want = a_data_out;
        end else begin
          want = model_q.pop_front();
        end
      end
      if (!(use_model && want === a_data_out && model_q.size() == 0 && 1'b0))
        check({name, "_data"}, a_data_out, want);
    end
    for (int i = 0; i < dly; i++) step();
    a_ack_in = 1'b1;
    n = 0;
    do begin step(); n++; end while (a_req_out !== 1'b0 && n < 200);
    if (a_req_out !== 1'b0) timeout_fail({name, "_req_fall"});
    a_ack_in = 1'b0;
  endtask

  initial begin
    // cycle table for A: {req_in, data_in, ack_in} -> outputs after the edge
    vecs[0]  = '{1,1,0, 1,0,0,1,0,0};
    vecs[1]  = '{0,1,0, 0,1,1,1,0,0};
    vecs[2]  = '{1,2,0, 1,1,1,2,0,0};
    vecs[3]  = '{0,2,0, 0,1,1,2,0,0};
    vecs[4]  = '{1,3,0, 1,1,1,3,0,0};
    vecs[5]  = '{0,3,0, 0,1,1,3,0,0};
    vecs[6]  = '{0,3,1, 0,0,1,2,0,0};
    vecs[7]  = '{0,3,0, 0,1,2,2,0,0};
    vecs[8]  = '{0,3,1, 0,0,2,1,0,0};
    vecs[9]  = '{0,3,0, 0,1,3,1,0,0};
    vecs[10] = '{0,3,1, 0,0,3,0,0,1};
    vecs[11] = '{0,3,0, 0,0,3,0,0,1};
    vecs[12] = '{1,4,0, 1,0,3,1,0,0};
    vecs[13] = '{0,4,0, 0,1,4,1,0,0};
    vecs[14] = '{1,5,0, 1,1,4,2,0,0};
    vecs[15] = '{0,5,0, 0,1,4,2,0,0};
    vecs[16] = '{1,6,1, 1,0,4,2,0,0};
    vecs[17] = '{0,6,0, 0,1,5,2,0,0};

    // ---- reset state ----
    do_reset();
    rst_n = 1'b0;
    step();
    check("reset_a", {a_ack_out, a_req_out, a_data_out, a_count, a_full, a_empty}, 10'b00_000_000_01);
    check("reset_b", {b_ack_out, b_req_out, b_data_out, b_count, b_full, b_empty}, 10'b00_000_000_01);
    check("reset_c", {c_ack_out, c_req_out, c_data_out, c_count, c_full, c_empty}, 10'b00_000_000_01);
    rst_n = 1'b1;

    // ---- T1 + T4 cycle table on A ----
    for (int i = 0; i < 18; i++) begin
      a_req_in  = vecs[i].req[0];
      a_data_in = vecs[i].din[DW-1:0];
      a_ack_in  = vecs[i].ack[0];
      step();
      check($sformatf("table_row%0d", i),
            {a_ack_out, a_req_out, a_data_out, a_count, a_full, a_empty},
            {vecs[i].e_ack_out[0], vecs[i].e_req_out[0], vecs[i].e_dout[DW-1:0],
             vecs[i].e_count[CW-1:0], vecs[i].e_full[0], vecs[i].e_empty[0]});
    end
    a_req_in = 0; a_ack_in = 0;
    a_pop(3'd5, 1'b0, 0, "table_drain5");
    a_pop(3'd6, 1'b0, 0, "table_drain6");
    step();
    check("table_drained_empty", {a_count, a_empty}, {3'd0, 1'b1});

    // ---- T2 full on A ----
    do_reset();
    a_push(3'd5, 1'b0, "full_p5");
    a_push(3'd6, 1'b0, "full_p6");
    a_push(3'd7, 1'b0, "full_p7");
    a_push(3'd0, 1'b0, "full_p0");
    a_data_in = 3'd4;
    a_req_in  = 1'b1;
    step(); step(); step();
    check("full_stall", {a_full, a_ack_out, a_count}, {1'b1, 1'b0, 3'd4});
    check("full_head", {a_req_out, a_data_out}, {1'b1, 3'd5});
    a_ack_in = 1'b1;
    step();
    check("full_pop_count", {a_count, a_full, a_ack_out}, {3'd3, 1'b0, 1'b0});
    a_ack_in = 1'b0;
    step();
    check("full_refill", {a_ack_out, a_count, a_full}, {1'b1, 3'd4, 1'b1});
    a_req_in = 1'b0;
    step();
    a_pop(3'd6, 1'b0, 0, "full_d6");
    a_pop(3'd7, 1'b0, 1, "full_d7");
    a_pop(3'd0, 1'b0, 0, "full_d0");
    a_pop(3'd4, 1'b0, 2, "full_d4");
    step();
    check("full_empty_end", {a_count, a_empty, a_full}, {3'd0, 1'b1, 1'b0});

    // ---- T3 two-phase on B ----
    begin
      logic t;
      logic [DW-1:0] vals [3];
      int n;
      vals[0] = 3'd2; vals[1] = 3'd4; vals[2] = 3'd6;
      t = 1'b0;
      for (int i = 0; i < 3; i++) begin
        t = ~t;
        b_data_in = vals[i];
        b_req_in  = t;
        step();
        check($sformatf("b_ack_toggle%0d", i), b_ack_out, t);
      end
      step(); step();
      check("b_filled", {b_count, b_req_out, b_data_out}, {3'd3, 1'b1, 3'd2});
      for (int i = 0; i < 3; i++) begin
        n = 0;
        while (b_req_out === b_ack_in && n < 200) begin step(); n++; end
        if (b_req_out === b_ack_in) timeout_fail($sformatf("b_offer%0d", i));
        check($sformatf("b_data%0d", i), b_data_out, vals[i]);
        b_ack_in = b_req_out;
        step();
      end
      step(); step();
      check("b_drained", {b_count, b_empty}, {3'd0, 1'b1});
    end

    // ---- T5 synchroniser latency on C ----
    begin
      int n;
      c_data_in = 3'd3;
      c_req_in  = 1'b1;
      step();
      check("c_edge1", c_ack_out, 1'b0);
      step();
      check("c_edge2", c_ack_out, 1'b0);
      step();
      check("c_edge3", c_ack_out, 1'b1);
      c_req_in = 1'b0;
      n = 0;
      while (c_req_out !== 1'b1 && n < 50) begin step(); n++; end
      if (c_req_out !== 1'b1) timeout_fail("c_offer");
      check("c_data", c_data_out, 3'd3);
      c_ack_in = 1'b1;
      n = 0;
      while (c_req_out !== 1'b0 && n < 50) begin step(); n++; end
      if (c_req_out !== 1'b0) timeout_fail("c_pop");
      c_ack_in = 1'b0;
      step();
      check("c_empty", {c_count, c_empty, c_ack_out}, {3'd0, 1'b1, 1'b0});
    end

    // ---- T6 reset mid-handshake on A ----
    a_push(3'd3, 1'b0, "rst_p3");
    a_push(3'd2, 1'b0, "rst_p2");
    step();
    check("rst_pre", {a_count, a_req_out}, {3'd2, 1'b1});
    a_req_in  = 1'b1;
    a_data_in = 3'd7;
    rst_n = 1'b0;
    step();
    check("rst_mid", {a_ack_out, a_req_out, a_data_out, a_count, a_full, a_empty}, 10'b00_000_000_01);
    rst_n = 1'b1;
    a_req_in = 1'b0;
    step();
    a_push(3'd1, 1'b0, "rst_fresh");
    a_pop(3'd1, 1'b0, 0, "rst_fresh_pop");

    // ---- randomized producer/consumer against the queue model on A ----
    do_reset();
    model_q.delete();
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          int idle;
          a_push(DW'($urandom), 1'b1, $sformatf("rnd_push%0d", i));
          idle = $urandom_range(0, 3);
          for (int k = 0; k < idle; k++) step();
        end
      end
      begin
        for (int i = 0; i < 30; i++) begin
          a_pop('0, 1'b1, $urandom_range(0, 6), $sformatf("rnd_pop%0d", i));
        end
      end
    join
    step(); step();
    check("rnd_end", {a_count, a_empty, a_full}, {3'd0, 1'b1, 1'b0});
    check("rnd_model_empty", model_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
